// File: rtl/issue_scheduler_pkg.sv
// Shared types for the integer issue scheduler: op encodings, reservation
// station entry layout and issue slot payload.
package issue_scheduler_pkg;

    localparam int unsigned DEF_TAG_W = 4;
    localparam int unsigned DEF_XLEN  = 32;
    localparam int unsigned OP_W      = 3;

    typedef enum logic {
        GRP_ALU   = 1'b0,
        GRP_SHIFT = 1'b1
    } functional_group_t;

    typedef enum logic [OP_W-1:0] {
        ADDR  = 3'd0,
        SUBR  = 3'd1,
        ANDR  = 3'd2,
        ORR   = 3'd3,
        XORR  = 3'd4,
        SLTR  = 3'd5,
        SLTUR = 3'd6
    } alu_op_t;

    typedef enum logic [OP_W-1:0] {
        SLLR = 3'd0,
        SRLR = 3'd1,
        SRAR = 3'd2
    } shift_op_t;

    typedef struct packed {
        logic                 rdy;
        logic [DEF_TAG_W-1:0] tag;
        logic [DEF_XLEN-1:0]  val;
    } rs_src_t;

    typedef struct packed {
        logic                 valid;
        functional_group_t    group;
        alu_op_t              alu_op;
        shift_op_t            shift_op;
        rs_src_t              rs1;
        rs_src_t              rs2;
        logic [DEF_TAG_W-1:0] rd_tag;
    } rs_entry_t;

    typedef struct packed {
        logic [OP_W-1:0]      op;
        logic [DEF_XLEN-1:0]  src1;
        logic [DEF_XLEN-1:0]  src2;
        logic [DEF_TAG_W-1:0] rd_tag;
    } issue_slot_t;

    // A source that is already ready is never overwritten by a later broadcast.
    function automatic rs_src_t wake_src(input rs_src_t s, input logic cdb_v,
                                         input logic [DEF_TAG_W-1:0] cdb_tag,
                                         input logic [DEF_XLEN-1:0] cdb_val);
        rs_src_t r;
        r = s;
        if (!s.rdy && cdb_v && (s.tag == cdb_tag)) begin
            r.rdy = 1'b1;
            r.val = cdb_val;
        end
        return r;
    endfunction

endpackage

// File: rtl/issue_scheduler_rs_oldest_select.sv
// Priority picker: reports whether any entry is eligible and the lowest
// (oldest) eligible index.
module rs_oldest_select #(
    parameter int unsigned NUM_ENTRIES = 4,
    localparam int unsigned IDX_W = $clog2(NUM_ENTRIES)
) (
    input  logic [NUM_ENTRIES-1:0] i_eligible,
    output logic                   o_found,
    output logic [IDX_W-1:0]       o_idx
);

    always_comb begin
        o_found = |i_eligible;
        o_idx   = '0;
        for (int unsigned i = NUM_ENTRIES; i > 0; i--) begin
            if (i_eligible[i-1]) begin
                o_idx = IDX_W'(i - 1);
            end
        end
    end

endmodule

// File: rtl/issue_scheduler.sv
// Unified reservation station for the ALU and SHIFT units: collapsing age
// queue with CDB wakeup and one registered issue slot per functional group.
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 4,
    parameter int unsigned TAG_W       = DEF_TAG_W,
    parameter int unsigned XLEN        = DEF_XLEN
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               disp_valid_i,
    output logic                               disp_ready_o,
    input  functional_group_t                  disp_group_i,
    input  alu_op_t                            disp_alu_op_i,
    input  shift_op_t                          disp_shift_op_i,
    input  logic                               disp_rs1_rdy_i,
    input  logic [TAG_W-1:0]                   disp_rs1_tag_i,
    input  logic [XLEN-1:0]                    disp_rs1_val_i,
    input  logic                               disp_rs2_rdy_i,
    input  logic [TAG_W-1:0]                   disp_rs2_tag_i,
    input  logic [XLEN-1:0]                    disp_rs2_val_i,
    input  logic [TAG_W-1:0]                   disp_rd_tag_i,
    input  logic                               cdb_valid_i,
    input  logic [TAG_W-1:0]                   cdb_tag_i,
    input  logic [XLEN-1:0]                    cdb_val_i,
    output logic                               alu_issue_valid_o,
    input  logic                               alu_issue_ready_i,
    output alu_op_t                            alu_op_o,
    output logic [XLEN-1:0]                    alu_src1_o,
    output logic [XLEN-1:0]                    alu_src2_o,
    output logic [TAG_W-1:0]                   alu_rd_tag_o,
    output logic                               shift_issue_valid_o,
    input  logic                               shift_issue_ready_i,
    output shift_op_t                          shift_op_o,
    output logic [XLEN-1:0]                    shift_src1_o,
    output logic [XLEN-1:0]                    shift_src2_o,
    output logic [TAG_W-1:0]                   shift_rd_tag_o,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]   occupancy_o
);

    localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
    localparam int unsigned CNT_W = $clog2(NUM_ENTRIES + 1);

    rs_entry_t [NUM_ENTRIES-1:0] r_rs;
    logic [CNT_W-1:0]            r_occ;
    logic                        r_alu_valid;
    logic                        r_sh_valid;
    issue_slot_t                 r_alu_slot;
    issue_slot_t                 r_sh_slot;

    logic [NUM_ENTRIES-1:0]      w_alu_elig;
    logic [NUM_ENTRIES-1:0]      w_sh_elig;
    logic [NUM_ENTRIES-1:0]      w_remove;
    logic                        w_alu_found;
    logic                        w_sh_found;
    logic [IDX_W-1:0]            w_alu_idx;
    logic [IDX_W-1:0]            w_sh_idx;
    logic                        w_alu_load;
    logic                        w_sh_load;
    logic                        w_disp_fire;
    issue_slot_t                 w_alu_pick;
    issue_slot_t                 w_sh_pick;
    rs_entry_t                   w_disp_entry;
    rs_entry_t                   w_tmp;
    rs_entry_t [NUM_ENTRIES-1:0] w_rs_next;
    logic [CNT_W-1:0]            w_cnt;
    logic [CNT_W-1:0]            w_occ_next;

    assign disp_ready_o = (r_occ < CNT_W'(NUM_ENTRIES));
    assign w_disp_fire  = disp_valid_i & disp_ready_o;

    always_comb begin
        w_alu_elig = '0;
        w_sh_elig  = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            w_alu_elig[i] = r_rs[i].valid && (r_rs[i].group == GRP_ALU) &&
                            r_rs[i].rs1.rdy && r_rs[i].rs2.rdy;
            w_sh_elig[i]  = r_rs[i].valid && (r_rs[i].group == GRP_SHIFT) &&
                            r_rs[i].rs1.rdy && r_rs[i].rs2.rdy;
        end
    end

    rs_oldest_select #(.NUM_ENTRIES(NUM_ENTRIES)) u_alu_select (
        .i_eligible (w_alu_elig),
        .o_found    (w_alu_found),
        .o_idx      (w_alu_idx)
    );

    rs_oldest_select #(.NUM_ENTRIES(NUM_ENTRIES)) u_shift_select (
        .i_eligible (w_sh_elig),
        .o_found    (w_sh_found),
        .o_idx      (w_sh_idx)
    );

    assign w_alu_load = w_alu_found & (~r_alu_valid | alu_issue_ready_i);
    assign w_sh_load  = w_sh_found  & (~r_sh_valid  | shift_issue_ready_i);

    always_comb begin
        w_alu_pick.op     = OP_W'(r_rs[w_alu_idx].alu_op);
        w_alu_pick.src1   = r_rs[w_alu_idx].rs1.val;
        w_alu_pick.src2   = r_rs[w_alu_idx].rs2.val;
        w_alu_pick.rd_tag = r_rs[w_alu_idx].rd_tag;
        w_sh_pick.op      = OP_W'(r_rs[w_sh_idx].shift_op);
        w_sh_pick.src1    = r_rs[w_sh_idx].rs1.val;
        w_sh_pick.src2    = r_rs[w_sh_idx].rs2.val;
        w_sh_pick.rd_tag  = r_rs[w_sh_idx].rd_tag;
    end

    always_comb begin
        w_remove = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            w_remove[i] = (w_alu_load && (w_alu_idx == IDX_W'(i))) ||
                          (w_sh_load  && (w_sh_idx  == IDX_W'(i)));
        end
    end

    always_comb begin
        w_disp_entry          = '0;
        w_disp_entry.valid    = 1'b1;
        w_disp_entry.group    = disp_group_i;
        w_disp_entry.alu_op   = disp_alu_op_i;
        w_disp_entry.shift_op = disp_shift_op_i;
        w_disp_entry.rs1      = wake_src({disp_rs1_rdy_i, disp_rs1_tag_i, disp_rs1_val_i},
                                         cdb_valid_i, cdb_tag_i, cdb_val_i);
        w_disp_entry.rs2      = wake_src({disp_rs2_rdy_i, disp_rs2_tag_i, disp_rs2_val_i},
                                         cdb_valid_i, cdb_tag_i, cdb_val_i);
        w_disp_entry.rd_tag   = disp_rd_tag_i;
    end

    // Survivors are packed down in age order while being woken; w_cnt ends
    // as occupancy minus removals, which is where a dispatch lands.
    always_comb begin
        w_rs_next = '0;
        w_tmp     = '0;
        w_cnt     = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (r_rs[i].valid && !w_remove[i]) begin
                w_tmp     = r_rs[i];
                w_tmp.rs1 = wake_src(r_rs[i].rs1, cdb_valid_i, cdb_tag_i, cdb_val_i);
                w_tmp.rs2 = wake_src(r_rs[i].rs2, cdb_valid_i, cdb_tag_i, cdb_val_i);
                w_rs_next[w_cnt[IDX_W-1:0]] = w_tmp;
                w_cnt = w_cnt + 1'b1;
            end
        end
        if (w_disp_fire) begin
            w_rs_next[w_cnt[IDX_W-1:0]] = w_disp_entry;
        end
        w_occ_next = w_cnt + CNT_W'(w_disp_fire);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rs        <= '0;
            r_occ       <= '0;
            r_alu_valid <= 1'b0;
            r_sh_valid  <= 1'b0;
            r_alu_slot  <= '0;
            r_sh_slot   <= '0;
        end else begin
            r_rs  <= w_rs_next;
            r_occ <= w_occ_next;
            if (w_alu_load) begin
                r_alu_valid <= 1'b1;
                r_alu_slot  <= w_alu_pick;
            end else if (alu_issue_ready_i) begin
                r_alu_valid <= 1'b0;
            end
            if (w_sh_load) begin
                r_sh_valid <= 1'b1;
                r_sh_slot  <= w_sh_pick;
            end else if (shift_issue_ready_i) begin
                r_sh_valid <= 1'b0;
            end
        end
    end

    assign alu_issue_valid_o   = r_alu_valid;
    assign alu_op_o            = alu_op_t'(r_alu_slot.op);
    assign alu_src1_o          = r_alu_slot.src1;
    assign alu_src2_o          = r_alu_slot.src2;
    assign alu_rd_tag_o        = r_alu_slot.rd_tag;
    assign shift_issue_valid_o = r_sh_valid;
    assign shift_op_o          = shift_op_t'(r_sh_slot.op);
    assign shift_src1_o        = r_sh_slot.src1;
    assign shift_src2_o        = r_sh_slot.src2;
    assign shift_rd_tag_o      = r_sh_slot.rd_tag;
    assign occupancy_o         = r_occ;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: table of single-instruction vectors
// plus hand sequences for wakeup, bypass, full, dual issue and reset.
module tb_issue_scheduler;
    import issue_scheduler_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              disp_valid;
    logic              disp_ready;
    functional_group_t disp_group;
    alu_op_t           disp_alu_op;
    shift_op_t         disp_shift_op;
    logic              rs1_rdy, rs2_rdy;
    logic [3:0]        rs1_tag, rs2_tag, rd_tag;
    logic [31:0]       rs1_val, rs2_val;
    logic              cdb_valid;
    logic [3:0]        cdb_tag;
    logic [31:0]       cdb_val;
    logic              alu_valid, alu_ready;
    alu_op_t           alu_op;
    logic [31:0]       alu_src1, alu_src2;
    logic [3:0]        alu_rd;
    logic              sh_valid, sh_ready;
    shift_op_t         sh_op;
    logic [31:0]       sh_src1, sh_src2;
    logic [3:0]        sh_rd;
    logic [2:0]        occ;

    int unsigned errors = 0;
    int unsigned checks = 0;

    issue_scheduler #(.NUM_ENTRIES(4), .TAG_W(4), .XLEN(32)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .disp_valid_i        (disp_valid),
        .disp_ready_o        (disp_ready),
        .disp_group_i        (disp_group),
        .disp_alu_op_i       (disp_alu_op),
        .disp_shift_op_i     (disp_shift_op),
        .disp_rs1_rdy_i      (rs1_rdy),
        .disp_rs1_tag_i      (rs1_tag),
        .disp_rs1_val_i      (rs1_val),
        .disp_rs2_rdy_i      (rs2_rdy),
        .disp_rs2_tag_i      (rs2_tag),
        .disp_rs2_val_i      (rs2_val),
        .disp_rd_tag_i       (rd_tag),
        .cdb_valid_i         (cdb_valid),
        .cdb_tag_i           (cdb_tag),
        .cdb_val_i           (cdb_val),
        .alu_issue_valid_o   (alu_valid),
        .alu_issue_ready_i   (alu_ready),
        .alu_op_o            (alu_op),
        .alu_src1_o          (alu_src1),
        .alu_src2_o          (alu_src2),
        .alu_rd_tag_o        (alu_rd),
        .shift_issue_valid_o (sh_valid),
        .shift_issue_ready_i (sh_ready),
        .shift_op_o          (sh_op),
        .shift_src1_o        (sh_src1),
        .shift_src2_o        (sh_src2),
        .shift_rd_tag_o      (sh_rd),
        .occupancy_o         (occ)
    );

    always #5 clk = ~clk;

    typedef struct {
        functional_group_t grp;
        logic [2:0]        op;
        logic [31:0]       v1;
        logic [31:0]       v2;
        logic [3:0]        rd;
        logic              e_alu;
        logic              e_sh;
        logic [2:0]        e_op;
        logic [31:0]       e_s1;
        logic [31:0]       e_s2;
        logic [3:0]        e_rd;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic no_disp();
        disp_valid    = 1'b0;
        disp_group    = GRP_ALU;
        disp_alu_op   = ADDR;
        disp_shift_op = SLLR;
        rs1_rdy = 1'b0; rs1_tag = '0; rs1_val = '0;
        rs2_rdy = 1'b0; rs2_tag = '0; rs2_val = '0;
        rd_tag  = '0;
    endtask

    task automatic no_cdb();
        cdb_valid = 1'b0;
        cdb_tag   = '0;
        cdb_val   = '0;
    endtask

    task automatic disp(input functional_group_t g, input logic [2:0] op,
                        input logic r1, input logic [3:0] t1, input logic [31:0] v1,
                        input logic r2, input logic [3:0] t2, input logic [31:0] v2,
                        input logic [3:0] rd);
        disp_valid    = 1'b1;
        disp_group    = g;
        disp_alu_op   = alu_op_t'(op);
        disp_shift_op = shift_op_t'(op);
        rs1_rdy = r1; rs1_tag = t1; rs1_val = v1;
        rs2_rdy = r2; rs2_tag = t2; rs2_val = v2;
        rd_tag  = rd;
    endtask

    task automatic drive_cdb(input logic [3:0] t, input logic [31:0] v);
        cdb_valid = 1'b1;
        cdb_tag   = t;
        cdb_val   = v;
    endtask

    // A1 S1 A2 S2 A3 dispatched back to back with both units stalled:
    // A1 and S1 end up in the slots, [A2,S2,A3] remain in the station.
    task automatic build_mixed();
        alu_ready = 1'b0;
        sh_ready  = 1'b0;
        disp(GRP_ALU,   3'(ADDR), 1'b1, 4'd0, 32'h100, 1'b1, 4'd0, 32'h101, 4'd1); step();
        disp(GRP_SHIFT, 3'(SLLR), 1'b1, 4'd0, 32'h200, 1'b1, 4'd0, 32'h201, 4'd2); step();
        disp(GRP_ALU,   3'(SUBR), 1'b1, 4'd0, 32'h300, 1'b1, 4'd0, 32'h301, 4'd3); step();
        disp(GRP_SHIFT, 3'(SRAR), 1'b1, 4'd0, 32'h400, 1'b1, 4'd0, 32'h401, 4'd4); step();
        disp(GRP_ALU,   3'(ANDR), 1'b1, 4'd0, 32'h500, 1'b1, 4'd0, 32'h501, 4'd5); step();
        no_disp();
    endtask

    initial begin
        vecs[0] = '{GRP_ALU,   3'd0, 32'd5,        32'd7,        4'd3,  1'b1, 1'b0, 3'd0, 32'd5,        32'd7,        4'd3};
        vecs[1] = '{GRP_ALU,   3'd1, 32'hFFFFFFFF, 32'h80000000, 4'd15, 1'b1, 1'b0, 3'd1, 32'hFFFFFFFF, 32'h80000000, 4'd15};
        vecs[2] = '{GRP_SHIFT, 3'd0, 32'h1,        32'd31,       4'd0,  1'b0, 1'b1, 3'd0, 32'h1,        32'd31,       4'd0};
        vecs[3] = '{GRP_SHIFT, 3'd2, 32'h80000000, 32'd4,        4'd7,  1'b0, 1'b1, 3'd2, 32'h80000000, 32'd4,        4'd7};
        vecs[4] = '{GRP_ALU,   3'd4, 32'h0,        32'h0,        4'd9,  1'b1, 1'b0, 3'd4, 32'h0,        32'h0,        4'd9};

        rst = 1'b1;
        alu_ready = 1'b0;
        sh_ready  = 1'b0;
        no_disp();
        no_cdb();
        step(); step();
        chk("reset occupancy", 32'(occ), 0);
        chk("reset disp_ready", 32'(disp_ready), 1);
        chk("reset alu_valid", 32'(alu_valid), 0);
        chk("reset shift_valid", 32'(sh_valid), 0);
        chk("reset alu_src1", alu_src1, 0);
        chk("reset shift_rd", 32'(sh_rd), 0);
        rst = 1'b0;
        step();

        // single instructions, both units ready
        alu_ready = 1'b1;
        sh_ready  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            disp(vecs[i].grp, vecs[i].op, 1'b1, 4'd0, vecs[i].v1, 1'b1, 4'd0, vecs[i].v2, vecs[i].rd);
            step();
            no_disp();
            chk($sformatf("vec%0d N+1 alu_valid", i), 32'(alu_valid), 0);
            step();
            chk($sformatf("vec%0d alu_valid", i), 32'(alu_valid), 32'(vecs[i].e_alu));
            chk($sformatf("vec%0d shift_valid", i), 32'(sh_valid), 32'(vecs[i].e_sh));
            if (vecs[i].e_alu) begin
                chk($sformatf("vec%0d alu_op", i), 32'(alu_op), 32'(vecs[i].e_op));
                chk($sformatf("vec%0d alu_src1", i), alu_src1, vecs[i].e_s1);
                chk($sformatf("vec%0d alu_src2", i), alu_src2, vecs[i].e_s2);
                chk($sformatf("vec%0d alu_rd", i), 32'(alu_rd), 32'(vecs[i].e_rd));
            end else begin
                chk($sformatf("vec%0d shift_op", i), 32'(sh_op), 32'(vecs[i].e_op));
                chk($sformatf("vec%0d shift_src1", i), sh_src1, vecs[i].e_s1);
                chk($sformatf("vec%0d shift_src2", i), sh_src2, vecs[i].e_s2);
                chk($sformatf("vec%0d shift_rd", i), 32'(sh_rd), 32'(vecs[i].e_rd));
            end
            step();
            chk($sformatf("vec%0d pulse alu", i), 32'(alu_valid), 0);
            chk($sformatf("vec%0d pulse shift", i), 32'(sh_valid), 0);
            chk($sformatf("vec%0d occupancy", i), 32'(occ), 0);
        end

        // wakeup: rs2 waits on tag 9, non-matching broadcast first
        disp(GRP_SHIFT, 3'(SLLR), 1'b1, 4'd0, 32'h10, 1'b0, 4'd9, 32'hDEAD, 4'd4);
        step();
        no_disp();
        drive_cdb(4'd8, 32'd77);
        step();
        drive_cdb(4'd9, 32'd2);
        chk("wake before bcast", 32'(sh_valid), 0);
        step();
        no_cdb();
        chk("wake bcast+1", 32'(sh_valid), 0);
        step();
        chk("wake bcast+2 valid", 32'(sh_valid), 1);
        chk("wake src1", sh_src1, 32'h10);
        chk("wake src2", sh_src2, 32'd2);
        chk("wake rd", 32'(sh_rd), 4);
        step();
        chk("wake drained", 32'(occ), 0);

        // bypass: broadcast in the dispatch cycle
        disp(GRP_SHIFT, 3'(SRLR), 1'b1, 4'd0, 32'h20, 1'b0, 4'd6, 32'hBEEF, 4'd5);
        drive_cdb(4'd6, 32'd3);
        step();
        no_disp();
        no_cdb();
        chk("bypass N+1", 32'(sh_valid), 0);
        step();
        chk("bypass N+2 valid", 32'(sh_valid), 1);
        chk("bypass op", 32'(sh_op), 32'(SRLR));
        chk("bypass src2", sh_src2, 32'd3);
        step();

        // ready rs1 (11, tag 5) must ignore broadcast 99; waiting rs2 on tag 5 takes it
        disp(GRP_ALU, 3'(ADDR), 1'b1, 4'd5, 32'd11, 1'b0, 4'd5, 32'd0, 4'd2);
        drive_cdb(4'd5, 32'd99);
        step();
        no_disp();
        step();
        no_cdb();
        chk("noover valid", 32'(alu_valid), 1);
        chk("noover src1", alu_src1, 32'd11);
        chk("noover src2", alu_src2, 32'd99);
        step();

        // full station with ALU stalled
        alu_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("fill%0d disp_ready", k), 32'(disp_ready), 1);
            disp(GRP_ALU, 3'(ADDR), 1'b1, 4'd0, 32'(10 + k), 1'b1, 4'd0, 32'(20 + k), 4'(1 + k));
            step();
        end
        no_disp();
        chk("full occupancy", 32'(occ), 4);
        chk("full disp_ready", 32'(disp_ready), 0);
        chk("full slot rd", 32'(alu_rd), 1);
        disp(GRP_ALU, 3'(ADDR), 1'b1, 4'd0, 32'd99, 1'b1, 4'd0, 32'd99, 4'd15);
        step();
        no_disp();
        chk("full reject occ", 32'(occ), 4);
        chk("hold valid", 32'(alu_valid), 1);
        chk("hold rd", 32'(alu_rd), 1);
        chk("hold src1", alu_src1, 32'd10);
        alu_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            step();
            chk($sformatf("drain%0d rd", k), 32'(alu_rd), 32'(1 + k));
            chk($sformatf("drain%0d src2", k), alu_src2, 32'(20 + k));
            chk($sformatf("drain%0d occ", k), 32'(occ), 32'(4 - k));
            chk($sformatf("drain%0d disp_ready", k), 32'(disp_ready), 1);
        end
        step();
        chk("drain end valid", 32'(alu_valid), 0);

        // dual issue and compaction with a simultaneous dispatch
        build_mixed();
        chk("mix occ", 32'(occ), 3);
        chk("mix alu rd", 32'(alu_rd), 1);
        chk("mix shift rd", 32'(sh_rd), 2);
        alu_ready = 1'b1;
        sh_ready  = 1'b1;
        step();
        chk("dual alu rd", 32'(alu_rd), 3);
        chk("dual alu op", 32'(alu_op), 32'(SUBR));
        chk("dual shift rd", 32'(sh_rd), 4);
        chk("dual shift op", 32'(sh_op), 32'(SRAR));
        chk("dual shift src1", sh_src1, 32'h400);
        chk("dual occ", 32'(occ), 1);
        disp(GRP_ALU, 3'(ORR), 1'b1, 4'd0, 32'h600, 1'b1, 4'd0, 32'h601, 4'd6);
        step();
        no_disp();
        chk("age alu rd", 32'(alu_rd), 5);
        chk("age shift valid", 32'(sh_valid), 0);
        chk("age occ", 32'(occ), 1);
        step();
        chk("late alu rd", 32'(alu_rd), 6);
        chk("late alu src2", alu_src2, 32'h601);
        chk("late occ", 32'(occ), 0);
        step();
        chk("mix end valid", 32'(alu_valid), 0);

        // reset in the middle of traffic
        build_mixed();
        chk("prereset occ", 32'(occ), 3);
        chk("prereset both", 32'({alu_valid, sh_valid}), 3);
        rst = 1'b1;
        step();
        chk("midreset occ", 32'(occ), 0);
        chk("midreset alu_valid", 32'(alu_valid), 0);
        chk("midreset shift_valid", 32'(sh_valid), 0);
        chk("midreset disp_ready", 32'(disp_ready), 1);
        chk("midreset alu_rd", 32'(alu_rd), 0);
        rst = 1'b0;
        alu_ready = 1'b1;
        sh_ready  = 1'b1;
        step(); step();
        chk("postreset alu_valid", 32'(alu_valid), 0);
        chk("postreset shift_valid", 32'(sh_valid), 0);
        chk("postreset occ", 32'(occ), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
